// File: rtl/pe_mrf_acc.sv
// pe_mrf_acc: PE-array processing element with register file, tappable delay line and counted accumulator.
// Optional feature macro PE_SAT_EN: signed saturation for ADD, SUB and ACC (wrap-around when undefined).
module pe_mrf_acc #(
  parameter int N_BITS    = 32,
  parameter int N_NEIGH   = 4,
  parameter int RF_DEPTH  = 4,
  parameter int DLY_DEPTH = 4,
  localparam int LS = $clog2(N_NEIGH + 3),
  localparam int LR = $clog2(RF_DEPTH),
  localparam int LD = $clog2(DLY_DEPTH),
  localparam int CW = 2*LS + 4 + 2*LR + LD
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [CW-1:0]             ctrl_pe_i,
  input  logic [7:0]                acc_len_i,
  input  logic                      pea_ready_i,
  input  logic [N_NEIGH*N_BITS-1:0] neigh_op_i,
  input  logic [N_NEIGH-1:0]        neigh_op_valid_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic [N_BITS-1:0]         pe_res_o,
  output logic                      delay_op_valid_o,
  output logic [N_BITS-1:0]         delay_op_o
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_MAX  = 3'd4,
    OP_MIN  = 3'd5,
    OP_PASS = 3'd6,
    OP_ACC  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_ACCUM = 2'd1,
    ACC_DONE  = 2'd2
  } acc_state_e;

  localparam logic [LS-1:0] SRC_SELF = LS'(N_NEIGH);
  localparam logic [LS-1:0] SRC_RF   = LS'(N_NEIGH + 1);
  localparam logic [LS-1:0] SRC_DLY  = LS'(N_NEIGH + 2);

  logic [LS-1:0] sel_a, sel_b;
  op_e           op;
  logic          rf_we;
  logic [LR-1:0] rf_widx, rf_ridx;
  logic [LD-1:0] dly_tap;

  assign sel_a   = ctrl_pe_i[LS-1:0];
  assign sel_b   = ctrl_pe_i[2*LS-1:LS];
  assign op      = op_e'(ctrl_pe_i[2*LS+2:2*LS]);
  assign rf_we   = ctrl_pe_i[2*LS+3];
  assign rf_widx = ctrl_pe_i[2*LS+4 +: LR];
  assign rf_ridx = ctrl_pe_i[2*LS+4+LR +: LR];
  assign dly_tap = ctrl_pe_i[2*LS+4+2*LR +: LD];

  acc_state_e               state_q, state_d;
  logic [N_BITS-1:0]        res_q, res_d;
  logic                     valid_q, valid_d;
  logic [N_BITS-1:0]        acc_q, acc_d;
  logic [7:0]               count_q, count_d;
  logic [7:0]               len_q, len_d;
  logic [N_BITS-1:0]        rf_q [RF_DEPTH];
  logic [N_BITS-1:0]        rf_d [RF_DEPTH];
  logic [N_BITS-1:0]        dly_data_q [DLY_DEPTH];
  logic [N_BITS-1:0]        dly_data_d [DLY_DEPTH];
  logic [DLY_DEPTH-1:0]     dly_vld_q, dly_vld_d;

  logic [N_BITS-1:0] op_a, op_b;
  logic              vld_a, vld_b;
  logic              fire;
  logic [7:0]        len_eff, count_inc;
  logic [N_BITS-1:0] add_res, sub_res, mul_res, acc_sum, alu_res;
  logic              rf_wr;
  logic [N_BITS-1:0] rf_wdata;

  assign pe_res_o         = res_q;
  assign valid_o          = valid_q;
  assign delay_op_o       = dly_data_q[dly_tap];
  assign delay_op_valid_o = dly_vld_q[dly_tap];
  assign ready_o          = pea_ready_i & (state_q != ACC_DONE);

  // Operand muxes; codes past the delay-line source read as an invalid zero.
  always_comb begin
    op_a  = '0;
    vld_a = 1'b0;
    op_b  = '0;
    vld_b = 1'b0;
    for (int i = 0; i < N_NEIGH; i++) begin
      if (sel_a == LS'(i)) begin
        op_a  = neigh_op_i[i*N_BITS +: N_BITS];
        vld_a = neigh_op_valid_i[i];
      end
      if (sel_b == LS'(i)) begin
        op_b  = neigh_op_i[i*N_BITS +: N_BITS];
        vld_b = neigh_op_valid_i[i];
      end
    end
    if (sel_a == SRC_SELF) begin
      op_a  = res_q;
      vld_a = 1'b1;
    end else if (sel_a == SRC_RF) begin
      op_a  = rf_q[rf_ridx];
      vld_a = 1'b1;
    end else if (sel_a == SRC_DLY) begin
      op_a  = delay_op_o;
      vld_a = delay_op_valid_o;
    end
    if (sel_b == SRC_SELF) begin
      op_b  = res_q;
      vld_b = 1'b1;
    end else if (sel_b == SRC_RF) begin
      op_b  = rf_q[rf_ridx];
      vld_b = 1'b1;
    end else if (sel_b == SRC_DLY) begin
      op_b  = delay_op_o;
      vld_b = delay_op_valid_o;
    end
  end

  assign fire      = vld_a & vld_b & ready_o;
  assign len_eff   = (acc_len_i == 8'd0) ? 8'd1 : acc_len_i;
  assign count_inc = count_q + 8'd1;
  assign mul_res   = op_a * op_b;

`ifdef PE_SAT_EN
  localparam logic [N_BITS-1:0] S_MAX = {1'b0, {(N_BITS-1){1'b1}}};
  localparam logic [N_BITS-1:0] S_MIN = {1'b1, {(N_BITS-1){1'b0}}};

  // Operands are sign-extended by one bit; a disagreeing top pair means overflow.
  function automatic logic [N_BITS-1:0] clamp(input logic [N_BITS:0] x);
    logic [N_BITS-1:0] r;
    if (x[N_BITS] != x[N_BITS-1]) r = x[N_BITS] ? S_MIN : S_MAX;
    else                          r = x[N_BITS-1:0];
    return r;
  endfunction

  assign add_res = clamp({op_a[N_BITS-1], op_a} + {op_b[N_BITS-1], op_b});
  assign sub_res = clamp({op_a[N_BITS-1], op_a} - {op_b[N_BITS-1], op_b});
  assign acc_sum = clamp({acc_q[N_BITS-1], acc_q} + {op_b[N_BITS-1], op_b});
`else
  assign add_res = op_a + op_b;
  assign sub_res = op_a - op_b;
  assign acc_sum = acc_q + op_b;
`endif

  always_comb begin
    case (op)
      OP_ADD:  alu_res = add_res;
      OP_SUB:  alu_res = sub_res;
      OP_MUL:  alu_res = mul_res;
      OP_MAX:  alu_res = ($signed(op_a) > $signed(op_b)) ? op_a : op_b;
      OP_MIN:  alu_res = ($signed(op_a) < $signed(op_b)) ? op_a : op_b;
      OP_PASS: alu_res = op_a;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ACC_IDLE;
    else          state_q <= state_d;
  end

  // Any op other than ACC drops the accumulator back to IDLE, discarding partial sums.
  always_comb begin
    state_d = state_q;
    if (op != OP_ACC) begin
      state_d = ACC_IDLE;
    end else begin
      case (state_q)
        ACC_IDLE:  if (fire) state_d = (len_eff == 8'd1) ? ACC_DONE : ACC_ACCUM;
        ACC_ACCUM: if (fire && (count_inc == len_q)) state_d = ACC_DONE;
        ACC_DONE:  if (pea_ready_i) state_d = ACC_IDLE;
        default:   state_d = ACC_IDLE;
      endcase
    end
  end

  always_comb begin
    res_d    = res_q;
    valid_d  = valid_q;
    acc_d    = acc_q;
    count_d  = count_q;
    len_d    = len_q;
    rf_wr    = 1'b0;
    rf_wdata = alu_res;
    if (op == OP_NOP) begin
      res_d   = '0;
      valid_d = 1'b0;
      count_d = '0;
    end else if (op == OP_ACC) begin
      case (state_q)
        ACC_IDLE: begin
          valid_d = 1'b0;
          if (fire) begin
            acc_d   = op_b;
            count_d = 8'd1;
            len_d   = len_eff;
            if (len_eff == 8'd1) begin
              res_d    = op_b;
              valid_d  = 1'b1;
              rf_wr    = rf_we;
              rf_wdata = op_b;
            end
          end
        end
        ACC_ACCUM: begin
          valid_d = 1'b0;
          if (fire) begin
            acc_d   = acc_sum;
            count_d = count_inc;
            if (count_inc == len_q) begin
              res_d    = acc_sum;
              valid_d  = 1'b1;
              rf_wr    = rf_we;
              rf_wdata = acc_sum;
            end
          end
        end
        ACC_DONE: begin
          res_d   = acc_q;
          valid_d = 1'b1;
          if (pea_ready_i) begin
            valid_d = 1'b0;
            count_d = '0;
          end
        end
        default: ;
      endcase
    end else begin
      count_d = '0;
      if (fire) begin
        res_d   = alu_res;
        valid_d = 1'b1;
        rf_wr   = rf_we;
      end else if (pea_ready_i) begin
        valid_d = 1'b0;
      end
    end
  end

  // Reads stay on rf_q, so a same-cycle read of the written index sees the old entry.
  always_comb begin
    rf_d = rf_q;
    if (rf_wr) rf_d[rf_widx] = rf_wdata;
  end

  always_comb begin
    dly_data_d = dly_data_q;
    dly_vld_d  = dly_vld_q;
    if (pea_ready_i) begin
      dly_data_d[0] = op_a;
      dly_vld_d[0]  = vld_a;
      for (int k = 1; k < DLY_DEPTH; k++) begin
        dly_data_d[k] = dly_data_q[k-1];
        dly_vld_d[k]  = dly_vld_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_q      <= '0;
      valid_q    <= 1'b0;
      acc_q      <= '0;
      count_q    <= '0;
      len_q      <= '0;
      rf_q       <= '{default: '0};
      dly_data_q <= '{default: '0};
      dly_vld_q  <= '0;
    end else begin
      res_q      <= res_d;
      valid_q    <= valid_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      len_q      <= len_d;
      rf_q       <= rf_d;
      dly_data_q <= dly_data_d;
      dly_vld_q  <= dly_vld_d;
    end
  end

endmodule

// File: tb/tb_pe_mrf_acc.sv
// tb_pe_mrf_acc: directed self-checking bench for pe_mrf_acc with the default 32-bit, 4-neighbour configuration.
// Overflow expectations follow the PE_SAT_EN macro when it is defined for the build.
module tb_pe_mrf_acc;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_MAX  = 3'd4;
  localparam logic [2:0] OP_MIN  = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;
  localparam logic [2:0] OP_ACC  = 3'd7;

  localparam logic [2:0] S_N0   = 3'd0;
  localparam logic [2:0] S_N1   = 3'd1;
  localparam logic [2:0] S_SELF = 3'd4;
  localparam logic [2:0] S_RF   = 3'd5;

`ifdef PE_SAT_EN
  localparam logic [31:0] EXP_ADD_OVF = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_SUB_OVF = 32'h8000_0000;
`else
  localparam logic [31:0] EXP_ADD_OVF = 32'h8000_0000;
  localparam logic [31:0] EXP_SUB_OVF = 32'h7FFF_FFFF;
`endif

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic [15:0]  ctrl_pe_i;
  logic [7:0]   acc_len_i;
  logic         pea_ready_i;
  logic [127:0] neigh_op_i;
  logic [3:0]   neigh_op_valid_i;
  logic         ready_o;
  logic         valid_o;
  logic [31:0]  pe_res_o;
  logic         delay_op_valid_o;
  logic [31:0]  delay_op_o;

  int checks   = 0;
  int failures = 0;

  pe_mrf_acc #(
    .N_BITS(32), .N_NEIGH(4), .RF_DEPTH(4), .DLY_DEPTH(4)
  ) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .ctrl_pe_i(ctrl_pe_i),
    .acc_len_i(acc_len_i),
    .pea_ready_i(pea_ready_i),
    .neigh_op_i(neigh_op_i),
    .neigh_op_valid_i(neigh_op_valid_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .pe_res_o(pe_res_o),
    .delay_op_valid_o(delay_op_valid_o),
    .delay_op_o(delay_op_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] mkCtrl(input logic [2:0] sa, input logic [2:0] sb,
                                         input logic [2:0] op, input logic we,
                                         input logic [1:0] widx, input logic [1:0] ridx,
                                         input logic [1:0] tap);
    return {tap, ridx, widx, we, op, sb, sa};
  endfunction

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic [15:0] ctrl, input logic [31:0] n0, input logic [31:0] n1,
                               input logic [3:0] vld, input logic [7:0] len, input logic rdy);
    ctrl_pe_i        = ctrl;
    neigh_op_i       = {64'd0, n1, n0};
    neigh_op_valid_i = vld;
    acc_len_i        = len;
    pea_ready_i      = rdy;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] c;
    rst_n_i          = 1'b0;
    ctrl_pe_i        = '0;
    acc_len_i        = '0;
    pea_ready_i      = 1'b1;
    neigh_op_i       = '0;
    neigh_op_valid_i = '0;
    #22;
    checkOutput("rst_res", pe_res_o, 32'd0);
    checkOutput("rst_valid", valid_o, 32'd0);
    checkOutput("rst_dly", delay_op_o, 32'd0);
    checkOutput("rst_dly_valid", delay_op_valid_o, 32'd0);
    checkOutput("rst_ready", ready_o, 32'd1);
    rst_n_i = 1'b1;

    // Plain ALU ops, one cycle latency
    c = mkCtrl(S_N0, S_N1, OP_ADD, 1'b0, 2'd0, 2'd0, 2'd0);
    applyStimulus(c, 32'd5, 32'd7, 4'b0011, 8'd0, 1'b1);
    checkOutput("add_res", pe_res_o, 32'd12);
    checkOutput("add_valid", valid_o, 32'd1);
    applyStimulus(c, 32'd5, 32'd7, 4'b0000, 8'd0, 1'b1);
    checkOutput("add_invalid_valid", valid_o, 32'd0);
    applyStimulus(mkCtrl(S_N0, S_N1, OP_SUB, 1'b0, 2'd0, 2'd0, 2'd0), 32'd5, 32'd7, 4'b0011, 8'd0, 1'b1);
    checkOutput("sub_res", pe_res_o, 32'hFFFF_FFFE);
    applyStimulus(mkCtrl(S_N0, S_N1, OP_MUL, 1'b0, 2'd0, 2'd0, 2'd0), 32'h0001_0000, 32'h0001_0003, 4'b0011, 8'd0, 1'b1);
    checkOutput("mul_res", pe_res_o, 32'h0003_0000);
    applyStimulus(mkCtrl(S_N0, S_N1, OP_MAX, 1'b0, 2'd0, 2'd0, 2'd0), 32'hFFFF_FFFD, 32'd2, 4'b0011, 8'd0, 1'b1);
    checkOutput("max_res", pe_res_o, 32'd2);
    applyStimulus(mkCtrl(S_N0, S_N1, OP_MIN, 1'b0, 2'd0, 2'd0, 2'd0), 32'hFFFF_FFFD, 32'd2, 4'b0011, 8'd0, 1'b1);
    checkOutput("min_res", pe_res_o, 32'hFFFF_FFFD);
    applyStimulus(c, 32'd1, 32'd1, 4'b0011, 8'd0, 1'b0);
    checkOutput("stall_ready", ready_o, 32'd0);
    checkOutput("stall_res", pe_res_o, 32'hFFFF_FFFD);
    checkOutput("stall_valid", valid_o, 32'd1);
    applyStimulus(mkCtrl(S_N0, S_N1, OP_NOP, 1'b0, 2'd0, 2'd0, 2'd0), 32'd3, 32'd4, 4'b0011, 8'd0, 1'b1);
    checkOutput("nop_res", pe_res_o, 32'd0);
    checkOutput("nop_valid", valid_o, 32'd0);

    // Signed overflow boundaries
    applyStimulus(c, 32'h7FFF_FFFF, 32'd1, 4'b0011, 8'd0, 1'b1);
    checkOutput("add_ovf", pe_res_o, EXP_ADD_OVF);
    applyStimulus(mkCtrl(S_N0, S_N1, OP_SUB, 1'b0, 2'd0, 2'd0, 2'd0), 32'h8000_0000, 32'd1, 4'b0011, 8'd0, 1'b1);
    checkOutput("sub_ovf", pe_res_o, EXP_SUB_OVF);

    // Register file write, old-value read on same-index write, SELF source
    applyStimulus(mkCtrl(S_N0, S_N0, OP_PASS, 1'b1, 2'd2, 2'd0, 2'd0), 32'h0000_00A5, 32'd0, 4'b0001, 8'd0, 1'b1);
    checkOutput("rf_pass", pe_res_o, 32'h0000_00A5);
    applyStimulus(mkCtrl(S_RF, S_N0, OP_ADD, 1'b1, 2'd2, 2'd2, 2'd0), 32'd1, 32'd0, 4'b0001, 8'd0, 1'b1);
    checkOutput("rf_read", pe_res_o, 32'h0000_00A6);
    applyStimulus(mkCtrl(S_RF, S_N0, OP_ADD, 1'b1, 2'd2, 2'd2, 2'd0), 32'd1, 32'd0, 4'b0001, 8'd0, 1'b1);
    checkOutput("rf_writeback", pe_res_o, 32'h0000_00A7);
    applyStimulus(mkCtrl(S_SELF, S_N0, OP_ADD, 1'b0, 2'd0, 2'd0, 2'd0), 32'd1, 32'd0, 4'b0001, 8'd0, 1'b1);
    checkOutput("self_add", pe_res_o, 32'h0000_00A8);

    // Accumulate run of three, then a run of two with acc_len changed mid-run and a DONE stall
    applyStimulus(mkCtrl(S_N0, S_N1, OP_NOP, 1'b0, 2'd0, 2'd0, 2'd0), 32'd0, 32'd0, 4'b0000, 8'd0, 1'b1);
    c = mkCtrl(S_N0, S_N1, OP_ACC, 1'b0, 2'd0, 2'd0, 2'd0);
    applyStimulus(c, 32'd0, 32'd2, 4'b0011, 8'd3, 1'b1);
    checkOutput("acc3_c1_valid", valid_o, 32'd0);
    applyStimulus(c, 32'd0, 32'd3, 4'b0011, 8'd3, 1'b1);
    checkOutput("acc3_c2_valid", valid_o, 32'd0);
    applyStimulus(c, 32'd0, 32'd4, 4'b0011, 8'd3, 1'b1);
    checkOutput("acc3_res", pe_res_o, 32'd9);
    checkOutput("acc3_valid", valid_o, 32'd1);
    applyStimulus(c, 32'd0, 32'd0, 4'b0000, 8'd3, 1'b1);
    checkOutput("acc3_valid_drop", valid_o, 32'd0);
    checkOutput("acc3_ready_back", ready_o, 32'd1);

    applyStimulus(c, 32'd0, 32'd4, 4'b0011, 8'd2, 1'b1);
    checkOutput("acc2_c1_valid", valid_o, 32'd0);
    applyStimulus(c, 32'd0, 32'd5, 4'b0011, 8'd5, 1'b1);
    checkOutput("acc2_res", pe_res_o, 32'd9);
    checkOutput("acc2_valid", valid_o, 32'd1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(c, 32'd0, 32'd0, 4'b0000, 8'd5, 1'b0);
      checkOutput("done_stall_ready", ready_o, 32'd0);
      checkOutput("done_stall_res", pe_res_o, 32'd9);
      checkOutput("done_stall_valid", valid_o, 32'd1);
    end
    applyStimulus(c, 32'd0, 32'd0, 4'b0000, 8'd5, 1'b1);
    checkOutput("done_release_valid", valid_o, 32'd0);

    // acc_len of zero behaves as one
    applyStimulus(c, 32'd0, 32'd7, 4'b0011, 8'd0, 1'b1);
    checkOutput("acc0_res", pe_res_o, 32'd7);
    checkOutput("acc0_valid", valid_o, 32'd1);
    applyStimulus(c, 32'd0, 32'd0, 4'b0000, 8'd0, 1'b1);
    checkOutput("acc0_drop", valid_o, 32'd0);

    // Abort mid-accumulation: partial sum 10 must be discarded
    applyStimulus(c, 32'd0, 32'd10, 4'b0011, 8'd3, 1'b1);
    checkOutput("abort_accum_valid", valid_o, 32'd0);
    applyStimulus(mkCtrl(S_N0, S_N1, OP_ADD, 1'b0, 2'd0, 2'd0, 2'd0), 32'd1, 32'd2, 4'b0011, 8'd3, 1'b1);
    checkOutput("abort_add_res", pe_res_o, 32'd3);
    applyStimulus(c, 32'd0, 32'd5, 4'b0011, 8'd2, 1'b1);
    applyStimulus(c, 32'd0, 32'd6, 4'b0011, 8'd2, 1'b1);
    checkOutput("abort_new_run_res", pe_res_o, 32'd11);
    checkOutput("abort_new_run_valid", valid_o, 32'd1);
    applyStimulus(mkCtrl(S_N0, S_N1, OP_NOP, 1'b0, 2'd0, 2'd0, 2'd0), 32'd0, 32'd0, 4'b0000, 8'd0, 1'b1);

    // Delay line on tap 2: three cycles of latency, frozen while pea_ready_i is low
    c = mkCtrl(S_N0, S_N0, OP_PASS, 1'b0, 2'd0, 2'd0, 2'd2);
    applyStimulus(c, 32'd1, 32'd0, 4'b0001, 8'd0, 1'b1);
    applyStimulus(c, 32'd2, 32'd0, 4'b0001, 8'd0, 1'b1);
    applyStimulus(c, 32'd3, 32'd0, 4'b0001, 8'd0, 1'b1);
    checkOutput("dly_tap2_first", delay_op_o, 32'd1);
    checkOutput("dly_tap2_valid", delay_op_valid_o, 32'd1);
    applyStimulus(c, 32'd4, 32'd0, 4'b0001, 8'd0, 1'b1);
    checkOutput("dly_tap2_second", delay_op_o, 32'd2);
    applyStimulus(c, 32'd5, 32'd0, 4'b0001, 8'd0, 1'b0);
    checkOutput("dly_freeze1", delay_op_o, 32'd2);
    applyStimulus(c, 32'd5, 32'd0, 4'b0001, 8'd0, 1'b0);
    checkOutput("dly_freeze2", delay_op_o, 32'd2);
    applyStimulus(c, 32'd6, 32'd0, 4'b0001, 8'd0, 1'b1);
    checkOutput("dly_resume", delay_op_o, 32'd3);
    ctrl_pe_i = mkCtrl(S_N0, S_N0, OP_PASS, 1'b0, 2'd0, 2'd0, 2'd0);
    #1;
    checkOutput("dly_tap0", delay_op_o, 32'd6);

    // Asynchronous reset in the middle of an accumulation
    c = mkCtrl(S_N0, S_N1, OP_ACC, 1'b0, 2'd0, 2'd0, 2'd2);
    applyStimulus(c, 32'd1, 32'd2, 4'b0011, 8'd4, 1'b1);
    applyStimulus(c, 32'd1, 32'd3, 4'b0011, 8'd4, 1'b1);
    rst_n_i = 1'b0;
    #1;
    checkOutput("midrst_res", pe_res_o, 32'd0);
    checkOutput("midrst_valid", valid_o, 32'd0);
    checkOutput("midrst_dly", delay_op_o, 32'd0);
    checkOutput("midrst_dly_valid", delay_op_valid_o, 32'd0);
    #2;
    rst_n_i = 1'b1;
    applyStimulus(c, 32'd1, 32'd3, 4'b0011, 8'd1, 1'b1);
    checkOutput("postrst_acc_res", pe_res_o, 32'd3);
    checkOutput("postrst_acc_valid", valid_o, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
